// File: rtl/snake_engine.sv
// snake_engine
// Snake movement, growth and collision engine for the VGA snake game.
// The head and up to MAX_LEN body segments are held as grid-cell coordinates.
// Each update tick moves the snake one cell along its heading, shifts the
// body, consumes pending growth and checks for wall and self collision.
// Every cycle the incoming pixel position is tested against the head cell and
// the active body cells; the results are registered for the pixel mixer.
//
// Ports:
//   clk          pixel clock, rising edge
//   reset        asynchronous, active-high
//   update       single-cycle move tick
//   direction    requested direction (0 idle, 1 up, 2 down, 3 left, 4 right; 5-7 idle)
//   grow         single-cycle apple-eaten pulse, adds GROW pending segments
//   restart      synchronous return to the start position (wins over update/grow)
//   x_pos/y_pos  current pixel coordinate
//   head_active  registered: last pixel was inside the head cell
//   body_active  registered: last pixel was inside an active body segment
//   rgb          HEAD_RGB / BODY_RGB / 0 from the two registered flags
//   length       current body segment count
//   wall_hit     sticky wall-collision flag
//   self_hit     sticky self-collision flag
//   dead         engine is in DEAD
module snake_engine #(
  parameter int         CELL     = 10,
  parameter int         BIT      = 10,
  parameter int         GRID_W   = 64,
  parameter int         GRID_H   = 48,
  parameter int         CW       = 6,
  parameter int         MAX_LEN  = 16,
  parameter int         X_START  = 32,
  parameter int         Y_START  = 24,
  parameter int         WRAP     = 0,
  parameter int         GROW     = 2,
  parameter logic [2:0] HEAD_RGB = 3'b110,
  parameter logic [2:0] BODY_RGB = 3'b010
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           update,
  input  logic [2:0]     direction,
  input  logic           grow,
  input  logic           restart,
  input  logic [BIT-1:0] x_pos,
  input  logic [BIT-1:0] y_pos,
  output logic           head_active,
  output logic           body_active,
  output logic [2:0]     rgb,
  output logic [7:0]     length,
  output logic           wall_hit,
  output logic           self_hit,
  output logic           dead
);

  localparam int         PW       = BIT + CW;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  typedef enum logic [2:0] {D_IDLE = 3'd0, D_UP = 3'd1, D_DOWN = 3'd2,
                            D_LEFT = 3'd3, D_RIGHT = 3'd4} dir_t;
  typedef enum logic [1:0] {S_WAIT, S_RUN, S_DEAD} state_t;

  state_t        state;
  dir_t          heading;
  logic [CW-1:0] head_x, head_y;
  logic [CW-1:0] seg_x [MAX_LEN];
  logic [CW-1:0] seg_y [MAX_LEN];
  logic [7:0]    pending;

  function automatic logic is_opposite(input dir_t a, input dir_t b);
    case (a)
      D_UP:    return b == D_DOWN;
      D_DOWN:  return b == D_UP;
      D_LEFT:  return b == D_RIGHT;
      D_RIGHT: return b == D_LEFT;
      default: return 1'b0;
    endcase
  endfunction

  // Cell bounds are formed at BIT+CW width so cx*CELL+CELL never truncates.
  function automatic logic in_cell(input logic [CW-1:0] cx, input logic [CW-1:0] cy,
                                   input logic [BIT-1:0] px, input logic [BIT-1:0] py);
    logic [PW-1:0] x0, y0, xp, yp;
    x0 = PW'(cx) * PW'(CELL);
    y0 = PW'(cy) * PW'(CELL);
    xp = PW'(px);
    yp = PW'(py);
    return (xp >= x0) && (xp < x0 + PW'(CELL)) && (yp >= y0) && (yp < y0 + PW'(CELL));
  endfunction

  // Effective heading: a valid, non-reversing request replaces the heading.
  dir_t req_dir, eff_dir;
  always_comb begin
    case (direction)
      3'd1:    req_dir = D_UP;
      3'd2:    req_dir = D_DOWN;
      3'd3:    req_dir = D_LEFT;
      3'd4:    req_dir = D_RIGHT;
      default: req_dir = D_IDLE;
    endcase
    eff_dir = heading;
    if (req_dir != D_IDLE && !is_opposite(req_dir, heading)) eff_dir = req_dir;
  end

  // Next head cell; off_grid only asserts at an edge when wrapping is disabled.
  logic [CW-1:0] nx, ny;
  logic          off_grid;
  always_comb begin
    nx       = head_x;
    ny       = head_y;
    off_grid = 1'b0;
    case (eff_dir)
      D_UP:    if (head_y == '0) begin off_grid = (WRAP == 0); ny = CW'(GRID_H - 1); end
               else ny = head_y - CW'(1);
      D_DOWN:  if (head_y == CW'(GRID_H - 1)) begin off_grid = (WRAP == 0); ny = '0; end
               else ny = head_y + CW'(1);
      D_LEFT:  if (head_x == '0) begin off_grid = (WRAP == 0); nx = CW'(GRID_W - 1); end
               else nx = head_x - CW'(1);
      D_RIGHT: if (head_x == CW'(GRID_W - 1)) begin off_grid = (WRAP == 0); nx = '0; end
               else nx = head_x + CW'(1);
      default: ;
    endcase
  end

  logic do_move, commit, wall_move;
  assign do_move   = update && !restart && (state != S_DEAD) && (eff_dir != D_IDLE);
  assign commit    = do_move && !off_grid;
  assign wall_move = do_move && off_grid;

  // Growth: a grow pulse lands before the same-cycle move may consume it.
  logic [8:0] psum;
  logic [7:0] pend_g, pend_n, len_n;
  logic       consume;
  always_comb begin
    psum    = {1'b0, pending} + 9'(GROW);
    pend_g  = grow ? (psum[8] ? 8'hFF : psum[7:0]) : pending;
    consume = commit && (pend_g != 8'd0) && (length < MAX_LEN8);
    len_n   = consume ? length + 8'd1 : length;
    pend_n  = (len_n == MAX_LEN8) ? 8'd0 : (consume ? pend_g - 8'd1 : pend_g);
  end

  // New segment 0 is the old head and new segment k is old segment k-1.
  logic self_col;
  always_comb begin
    self_col = (len_n != 8'd0) && (nx == head_x) && (ny == head_y);
    for (int k = 1; k < MAX_LEN; k++)
      if ((8'(k) < len_n) && (seg_x[k-1] == nx) && (seg_y[k-1] == ny)) self_col = 1'b1;
  end

  logic head_hit, body_hit;
  always_comb begin
    head_hit = in_cell(head_x, head_y, x_pos, y_pos);
    body_hit = 1'b0;
    for (int k = 0; k < MAX_LEN; k++)
      if ((8'(k) < length) && in_cell(seg_x[k], seg_y[k], x_pos, y_pos)) body_hit = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_WAIT;
      heading     <= D_IDLE;
      head_x      <= CW'(X_START);
      head_y      <= CW'(Y_START);
      length      <= 8'd0;
      pending     <= 8'd0;
      wall_hit    <= 1'b0;
      self_hit    <= 1'b0;
      head_active <= 1'b0;
      body_active <= 1'b0;
    end else begin
      head_active <= head_hit;
      body_active <= body_hit;
      if (restart) begin
        state    <= S_WAIT;
        heading  <= D_IDLE;
        head_x   <= CW'(X_START);
        head_y   <= CW'(Y_START);
        length   <= 8'd0;
        pending  <= 8'd0;
        wall_hit <= 1'b0;
        self_hit <= 1'b0;
      end else begin
        pending <= pend_n;
        if (commit) begin
          head_x  <= nx;
          head_y  <= ny;
          length  <= len_n;
          heading <= eff_dir;
          if (self_col) begin
            self_hit <= 1'b1;
            state    <= S_DEAD;
          end else begin
            state    <= S_RUN;
          end
        end else if (wall_move) begin
          heading  <= eff_dir;
          wall_hit <= 1'b1;
          state    <= S_DEAD;
        end
      end
    end
  end

  // Segment storage needs no reset: entries at or beyond length are masked.
  always_ff @(posedge clk) begin
    if (commit) begin
      seg_x[0] <= head_x;
      seg_y[0] <= head_y;
      for (int k = 1; k < MAX_LEN; k++) begin
        seg_x[k] <= seg_x[k-1];
        seg_y[k] <= seg_y[k-1];
      end
    end
  end

  assign dead = (state == S_DEAD);
  assign rgb  = head_active ? HEAD_RGB : (body_active ? BODY_RGB : 3'b000);

endmodule

// File: tb/tb_snake_engine.sv
module tb_snake_engine;
  localparam int CELL = 10, GW = 64, GH = 48, ML = 16, GR = 2, XS = 32, YS = 24;
  localparam logic [2:0] IDLE = 3'd0, UP = 3'd1, DOWN = 3'd2, LEFT = 3'd3, RIGHT = 3'd4;

  logic       clk = 1'b0;
  logic       reset, update, grow, restart;
  logic [2:0] direction;
  logic [9:0] x_pos, y_pos;
  logic       head_active, body_active, wall_hit, self_hit, dead;
  logic [2:0] rgb;
  logic [7:0] length;
  logic       w_head_active, w_body_active, w_wall_hit, w_self_hit, w_dead;
  logic [2:0] w_rgb;
  logic [7:0] w_length;

  snake_engine #(.WRAP(0)) dut (
    .clk(clk), .reset(reset), .update(update), .direction(direction), .grow(grow),
    .restart(restart), .x_pos(x_pos), .y_pos(y_pos), .head_active(head_active),
    .body_active(body_active), .rgb(rgb), .length(length), .wall_hit(wall_hit),
    .self_hit(self_hit), .dead(dead));

  snake_engine #(.WRAP(1)) dut_w (
    .clk(clk), .reset(reset), .update(update), .direction(direction), .grow(grow),
    .restart(restart), .x_pos(x_pos), .y_pos(y_pos), .head_active(w_head_active),
    .body_active(w_body_active), .rgb(w_rgb), .length(w_length), .wall_hit(w_wall_hit),
    .self_hit(w_self_hit), .dead(w_dead));

  // clock / reset block
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // reference model: head cell plus a queue of body cells, newest first
  int m_hx, m_hy, m_len, m_pend, m_heading;
  bit m_wall, m_self, m_dead;
  int m_bx[$];
  int m_by[$];

  function automatic int dxf(input int d);
    return (d == 4) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int dyf(input int d);
    return (d == 2) ? 1 : (d == 1) ? -1 : 0;
  endfunction

  task automatic model_reset();
    m_hx = XS; m_hy = YS; m_len = 0; m_pend = 0; m_heading = 0;
    m_wall = 0; m_self = 0; m_dead = 0;
    m_bx.delete(); m_by.delete();
  endtask

  task automatic model_step(input logic upd, input logic [2:0] dir, input logic grw, input logic rs);
    int d, nx, ny;
    if (rs) begin
      model_reset();
      return;
    end
    if (grw) m_pend = (m_pend + GR > 255) ? 255 : m_pend + GR;
    if (upd && !m_dead) begin
      d = (dir >= 1 && dir <= 4) ? int'(dir) : 0;
      if (d != 0 && !(m_heading != 0 && dxf(d) == -dxf(m_heading) && dyf(d) == -dyf(m_heading)))
        m_heading = d;
      if (m_heading != 0) begin
        nx = m_hx + dxf(m_heading);
        ny = m_hy + dyf(m_heading);
        if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
          m_wall = 1; m_dead = 1;
        end else begin
          m_bx.push_front(m_hx); m_by.push_front(m_hy);
          if (m_pend > 0 && m_len < ML) begin m_len++; m_pend--; end
          while (m_bx.size() > m_len) begin void'(m_bx.pop_back()); void'(m_by.pop_back()); end
          m_hx = nx; m_hy = ny;
          foreach (m_bx[i]) if (m_bx[i] == m_hx && m_by[i] == m_hy) begin m_self = 1; m_dead = 1; end
        end
      end
    end
    if (m_len == ML) m_pend = 0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_length"}, 32'(length), 32'(m_len));
    check({tag, "_wall"}, 32'(wall_hit), 32'(m_wall));
    check({tag, "_self"}, 32'(self_hit), 32'(m_self));
    check({tag, "_dead"}, 32'(dead), 32'(m_dead));
  endtask

  // driver tasks
  task automatic step(input string tag, input logic upd, input logic [2:0] dir,
                      input logic grw, input logic rs);
    update = upd; direction = dir; grow = grw; restart = rs;
    @(posedge clk); #1;
    update = 0; direction = IDLE; grow = 0; restart = 0;
    model_step(upd, dir, grw, rs);
    check_status(tag);
  endtask

  task automatic probe_px(input string tag, input int px, input int py);
    bit eh, eb;
    int cx, cy;
    x_pos = 10'(px); y_pos = 10'(py);
    @(posedge clk); #1;
    cx = px / CELL; cy = py / CELL;
    eh = (cx == m_hx && cy == m_hy);
    eb = 0;
    foreach (m_bx[i]) if (m_bx[i] == cx && m_by[i] == cy) eb = 1;
    check({tag, "_head"}, 32'(head_active), 32'(eh));
    check({tag, "_body"}, 32'(body_active), 32'(eb));
    check({tag, "_rgb"}, 32'(rgb), eh ? 32'd6 : (eb ? 32'd2 : 32'd0));
  endtask

  task automatic probe_cell(input string tag, input int cx, input int cy);
    probe_px(tag, cx * CELL + int'($urandom_range(0, CELL - 1)),
                  cy * CELL + int'($urandom_range(0, CELL - 1)));
  endtask

  initial begin
    int idx;
    reset = 1; update = 0; grow = 0; restart = 0; direction = IDLE; x_pos = 0; y_pos = 0;
    model_reset();
    #12;
    check("rst_head_active", 32'(head_active), 0);
    check("rst_body_active", 32'(body_active), 0);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_length", 32'(length), 0);
    check("rst_wall", 32'(wall_hit), 0);
    check("rst_self", 32'(self_hit), 0);
    check("rst_dead", 32'(dead), 0);
    @(posedge clk); #1;
    reset = 0;

    // first move right from (32,24)
    step("mv1", 1, RIGHT, 0, 0);
    probe_px("mv1_px", 330, 240);
    check("mv1_head_at_33", 32'(head_active), 1);
    probe_px("mv1_old", 329, 240);

    // one grow, then three moves: length 1, 2, 2
    step("grow1", 0, IDLE, 1, 0);
    step("g_mv1", 1, RIGHT, 0, 0);
    check("g_len1", 32'(length), 1);
    step("g_mv2", 1, RIGHT, 0, 0);
    check("g_len2", 32'(length), 2);
    step("g_mv3", 1, RIGHT, 0, 0);
    check("g_len3", 32'(length), 2);
    probe_cell("g_body35", 35, 24);
    check("g_body35_on", 32'(body_active), 1);
    probe_cell("g_body34", 34, 24);
    probe_px("g_body_edge", 339, 249);
    probe_px("g_past_tail", 339, 250);

    // reversal request is ignored
    step("rev", 1, LEFT, 0, 0);
    probe_px("rev_px", 375, 245);
    check("rev_head_37", 32'(head_active), 1);

    // drive to column 63, then hit the right wall
    for (int i = 0; i < 26; i++) step("to_edge", 1, RIGHT, 0, 0);
    probe_px("edge_px", 635, 245);
    step("wall", 1, RIGHT, 0, 0);
    check("wall_flag", 32'(wall_hit), 1);
    check("wall_dead", 32'(dead), 1);
    probe_px("wall_stay", 635, 245);
    check("wall_head_63", 32'(head_active), 1);
    check("wrap_no_wall", 32'(w_wall_hit), 0);
    check("wrap_alive", 32'(w_dead), 0);
    x_pos = 10'd5; y_pos = 10'd245;
    @(posedge clk); #1;
    check("wrap_head_col0", 32'(w_head_active), 1);
    check("wrap_body_col63", 32'(w_body_active), 0);
    step("dead_upd", 1, UP, 0, 0);
    probe_px("dead_frozen", 635, 245);
    step("restart", 0, IDLE, 0, 1);
    probe_px("restart_px", 325, 245);
    check("restart_head", 32'(head_active), 1);

    // length 4, then UP, LEFT, DOWN bites the body
    step("sc_g1", 0, IDLE, 1, 0);
    step("sc_g2", 0, IDLE, 1, 0);
    for (int i = 0; i < 4; i++) step("sc_run", 1, RIGHT, 0, 0);
    check("sc_len4", 32'(length), 4);
    step("sc_up", 1, UP, 0, 0);
    step("sc_left", 1, LEFT, 0, 0);
    check("sc_alive", 32'(dead), 0);
    step("sc_down", 1, DOWN, 0, 0);
    check("sc_self_hit", 32'(self_hit), 1);
    check("sc_dead", 32'(dead), 1);
    probe_px("sc_overlap", 355, 245);

    // restart together with update and grow: restart wins
    step("rs_upd", 1, RIGHT, 1, 1);
    check("rs_upd_len", 32'(length), 0);
    check("rs_upd_dead", 32'(dead), 0);
    probe_px("rs_upd_px", 325, 245);
    step("rs_mv", 1, RIGHT, 0, 0);
    check("rs_mv_len", 32'(length), 0);
    step("rs_mv2", 1, DOWN, 0, 0);
    step("rs_run", 1, LEFT, 0, 1);
    probe_px("rs_run_px", 325, 245);

    // asynchronous reset in the middle of a move cycle
    step("ar_g", 0, IDLE, 1, 0);
    step("ar_mv1", 1, UP, 0, 0);
    step("ar_mv2", 1, UP, 0, 0);
    update = 1; direction = LEFT;
    #3 reset = 1;
    #1;
    check("ar_length", 32'(length), 0);
    check("ar_dead", 32'(dead), 0);
    check("ar_head_active", 32'(head_active), 0);
    update = 0; direction = IDLE;
    #2 reset = 0;
    model_reset();
    @(posedge clk); #1;
    check_status("ar_after");
    probe_px("ar_px", 325, 245);

    // randomized walk against the model
    for (int i = 0; i < 400; i++) begin
      logic rs, gw, up;
      logic [2:0] dr;
      rs = m_dead || ($urandom_range(0, 49) == 0);
      gw = ($urandom_range(0, 3) == 0);
      up = ($urandom_range(0, 4) != 0);
      dr = 3'($urandom_range(0, 7));
      step("rnd", up, dr, gw, rs);
      case ($urandom_range(0, 2))
        0: probe_cell("rnd_head", m_hx, m_hy);
        1: if (m_bx.size() > 0) begin
             idx = int'($urandom_range(0, m_bx.size() - 1));
             probe_cell("rnd_body", m_bx[idx], m_by[idx]);
           end else begin
             probe_cell("rnd_head0", m_hx, m_hy);
           end
        default: probe_px("rnd_px", int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
